pixel_write_sink: RTL and testbench

- Receiving end of the pixel-plot stream that sprite and face drawers emit: x, y, colour and a plot strobe.
- Clips each plot to the 160x120 screen, computes the linear frame-buffer address and queues the write in a small FIFO.
- Drains the FIFO into the frame-buffer write port using a ready/valid handshake.
- Keeps drop/clip statistics and a dirty bounding box so the game controller knows which region was redrawn.

---
 rtl/pixel_write_sink_if.sv | 30 +++
 rtl/pixel_write_sink.sv | 176 +++++++++++++++++
 tb/tb_pixel_write_sink.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_sink_if.sv
// ============================================================================
// Module      : pixel_write_sink_if
// Description : Frame-buffer write port (valid/ready) between the pixel sink
//               and the frame-buffer memory.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pixel_write_sink_if;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_ready;

   modport master (
      output mem_we,
      output mem_addr,
      output mem_data,
      input  mem_ready
   );

   modport slave (
      input  mem_we,
      input  mem_addr,
      input  mem_data,
      output mem_ready
   );
endinterface

`default_nettype wire

// File: rtl/pixel_write_sink.sv
// ============================================================================
// Module      : pixel_write_sink
// Description : Clips pixel plots to the screen, queues frame-buffer writes in
//               a small FIFO and tracks drop/clip counts and a dirty box.
//               Optional macro COLOUR_KEY_EN makes colour 0 transparent.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_write_sink #(
   parameter int DEPTH    = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  wire logic          iClock,
   input  wire logic          iReset,
   input  wire logic [7:0]    iX,
   input  wire logic [6:0]    iY,
   input  wire logic [2:0]    iColour,
   input  wire logic          iPlot,
   input  wire logic          iClearBox,
   pixel_write_sink_if.master mem,
   output logic               oFull,
   output logic [7:0]         oDropCount,
   output logic [7:0]         oClipCount,
   output logic               oBoxValid,
   output logic [7:0]         oBoxX0,
   output logic [7:0]         oBoxX1,
   output logic [6:0]         oBoxY0,
   output logic [6:0]         oBoxY1
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
   localparam logic [7:0]       C_W_LIM = 8'(SCREEN_W);
   localparam logic [6:0]       C_H_LIM = 7'(SCREEN_H);

   logic [14:0]      r_addr_mem [DEPTH];
   logic [2:0]       r_data_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic [7:0]       r_drop_cnt;
   logic [7:0]       r_clip_cnt;
   logic             r_box_valid;
   logic [7:0]       r_box_x0;
   logic [7:0]       r_box_x1;
   logic [6:0]       r_box_y0;
   logic [6:0]       r_box_y1;

   logic [14:0]      w_addr;
   logic             w_in_range;
   logic             w_transparent;
   logic             w_full;
   logic             w_pop;
   logic             w_candidate;
   logic             w_push;
   logic             w_clip;
   logic             w_drop;

   // Constant-width shifts replace the multiplier for the native 160-wide screen.
   generate
      if (SCREEN_W == 160) begin : g_addr_shift
         assign w_addr = ({8'd0, iY} << 7) + ({8'd0, iY} << 5) + {7'd0, iX};
      end else begin : g_addr_mul
         assign w_addr = ({8'd0, iY} * 15'(SCREEN_W)) + {7'd0, iX};
      end
   endgenerate

`ifdef COLOUR_KEY_EN
   assign w_transparent = (iColour == 3'b000);
`else
   assign w_transparent = 1'b0;
`endif

   assign w_in_range  = (iX < C_W_LIM) && (iY < C_H_LIM);
   assign w_full      = (r_count == C_DEPTH);
   assign w_pop       = (r_count != '0) && mem.mem_ready;
   assign w_candidate = iPlot && w_in_range && !w_transparent;
   assign w_push      = w_candidate && (!w_full || w_pop);
   assign w_clip      = iPlot && !w_in_range;
   assign w_drop      = w_candidate && w_full && !w_pop;

   // FIFO storage and pointers; a full FIFO may push and pop in the same cycle.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_addr_mem[i] <= '0;
            r_data_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_addr_mem[r_wr_ptr] <= w_addr;
            r_data_mem[r_wr_ptr] <= iColour;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_drop_cnt <= '0;
         r_clip_cnt <= '0;
      end else if (iClearBox) begin
         r_drop_cnt <= '0;
         r_clip_cnt <= '0;
      end else begin
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
         if (w_clip && (r_clip_cnt != 8'hFF)) begin
            r_clip_cnt <= r_clip_cnt + 8'd1;
         end
      end
   end

   // A push coinciding with a clear re-seeds the box instead of leaving it empty.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_box_valid <= 1'b0;
         r_box_x0    <= '0;
         r_box_x1    <= '0;
         r_box_y0    <= '0;
         r_box_y1    <= '0;
      end else if (w_push) begin
         r_box_valid <= 1'b1;
         if (iClearBox || !r_box_valid) begin
            r_box_x0 <= iX;
            r_box_x1 <= iX;
            r_box_y0 <= iY;
            r_box_y1 <= iY;
         end else begin
            if (iX < r_box_x0) r_box_x0 <= iX;
            if (iX > r_box_x1) r_box_x1 <= iX;
            if (iY < r_box_y0) r_box_y0 <= iY;
            if (iY > r_box_y1) r_box_y1 <= iY;
         end
      end else if (iClearBox) begin
         r_box_valid <= 1'b0;
         r_box_x0    <= '0;
         r_box_x1    <= '0;
         r_box_y0    <= '0;
         r_box_y1    <= '0;
      end
   end

   assign mem.mem_we   = (r_count != '0);
   assign mem.mem_addr = r_addr_mem[r_rd_ptr];
   assign mem.mem_data = r_data_mem[r_rd_ptr];

   assign oFull      = w_full;
   assign oDropCount = r_drop_cnt;
   assign oClipCount = r_clip_cnt;
   assign oBoxValid  = r_box_valid;
   assign oBoxX0     = r_box_x0;
   assign oBoxX1     = r_box_x1;
   assign oBoxY0     = r_box_y0;
   assign oBoxY1     = r_box_y1;

endmodule

`default_nettype wire

// File: tb/tb_pixel_write_sink.sv
// ============================================================================
// Module      : tb_pixel_write_sink
// Description : Scoreboard bench for pixel_write_sink (honours COLOUR_KEY_EN).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_write_sink;
   localparam int DEPTH = 4;

   logic       iClock = 1'b0;
   logic       iReset;
   logic [7:0] iX;
   logic [6:0] iY;
   logic [2:0] iColour;
   logic       iPlot;
   logic       iClearBox;
   logic       oFull;
   logic [7:0] oDropCount;
   logic [7:0] oClipCount;
   logic       oBoxValid;
   logic [7:0] oBoxX0;
   logic [7:0] oBoxX1;
   logic [6:0] oBoxY0;
   logic [6:0] oBoxY1;

   pixel_write_sink_if mem ();

   pixel_write_sink #(
      .DEPTH    (DEPTH),
      .SCREEN_W (160),
      .SCREEN_H (120)
   ) dut (
      .iClock     (iClock),
      .iReset     (iReset),
      .iX         (iX),
      .iY         (iY),
      .iColour    (iColour),
      .iPlot      (iPlot),
      .iClearBox  (iClearBox),
      .mem        (mem),
      .oFull      (oFull),
      .oDropCount (oDropCount),
      .oClipCount (oClipCount),
      .oBoxValid  (oBoxValid),
      .oBoxX0     (oBoxX0),
      .oBoxX1     (oBoxX1),
      .oBoxY0     (oBoxY0),
      .oBoxY1     (oBoxY1)
   );

   always #5 iClock = ~iClock;

   int checks   = 0;
   int failures = 0;

   // Reference model: pending writes as a queue of addr*8+colour.
   int m_q[$];
   int exp_q[$];
   int m_drop, m_clip;
   bit m_valid;
   int m_x0, m_x1, m_y0, m_y1;
   int writes_seen = 0;
   int mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(negedge iClock) begin
      if (!iReset && mem.mem_we && mem.mem_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL write_unexpected actual_addr=%0d required=none", mem.mem_addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("write_addr", {17'd0, mem.mem_addr}, mon_e >> 3);
            chk("write_data", {29'd0, mem.mem_data}, mon_e & 7);
            writes_seen++;
         end
      end
   end

   task automatic model_step(input bit plot, input int x, input int y, input int col,
                             input bit ready, input bit clr);
      bit pop, full, inr, key, push;
      int a;
      pop  = (m_q.size() > 0) && ready;
      full = (m_q.size() == DEPTH);
      inr  = (x < 160) && (y < 120);
      key  = 1'b0;
`ifdef COLOUR_KEY_EN
      key  = (col == 0);
`endif
      push = plot && inr && !key && (!full || pop);
      if (clr) begin
         m_drop = 0; m_clip = 0; m_valid = 0;
         m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
      end else begin
         if (plot && !inr && m_clip < 255) m_clip++;
         if (plot && inr && !key && full && !pop && m_drop < 255) m_drop++;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
         a = y * 160 + x;
         m_q.push_back(a * 8 + col);
         exp_q.push_back(a * 8 + col);
         if (!m_valid) begin
            m_x0 = x; m_x1 = x; m_y0 = y; m_y1 = y;
         end else begin
            if (x < m_x0) m_x0 = x;
            if (x > m_x1) m_x1 = x;
            if (y < m_y0) m_y0 = y;
            if (y > m_y1) m_y1 = y;
         end
         m_valid = 1'b1;
      end
   endtask

   task automatic check_state();
      chk("mem_we",    {31'd0, mem.mem_we}, (m_q.size() != 0) ? 1 : 0);
      chk("full",      {31'd0, oFull},      (m_q.size() == DEPTH) ? 1 : 0);
      chk("drop_cnt",  {24'd0, oDropCount}, m_drop);
      chk("clip_cnt",  {24'd0, oClipCount}, m_clip);
      chk("box_valid", {31'd0, oBoxValid},  {31'd0, m_valid});
      chk("box_x0",    {24'd0, oBoxX0},     m_x0);
      chk("box_x1",    {24'd0, oBoxX1},     m_x1);
      chk("box_y0",    {25'd0, oBoxY0},     m_y0);
      chk("box_y1",    {25'd0, oBoxY1},     m_y1);
   endtask

   task automatic cycle(input bit plot, input int x, input int y, input int col,
                        input bit ready, input bit clr);
      iPlot         = plot;
      iX            = x[7:0];
      iY            = y[6:0];
      iColour       = col[2:0];
      mem.mem_ready = ready;
      iClearBox     = clr;
      model_step(plot, x, y, col, ready, clr);
      @(posedge iClock);
      #1;
      check_state();
   endtask

   task automatic do_reset();
      iReset        = 1'b1;
      iPlot         = 1'b0;
      iClearBox     = 1'b0;
      iX            = '0;
      iY            = '0;
      iColour       = '0;
      mem.mem_ready = 1'b0;
      m_q.delete();
      exp_q.delete();
      m_drop = 0; m_clip = 0; m_valid = 0;
      m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
      #2;
      chk("rst_we",   {31'd0, mem.mem_we},   0);
      chk("rst_addr", {17'd0, mem.mem_addr}, 0);
      chk("rst_data", {29'd0, mem.mem_data}, 0);
      check_state();
      @(posedge iClock);
      #1;
      iReset = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w0;
      int c, x, y;
      bit clr;

      do_reset();

      // Single pixel, 1-cycle latency.
      cycle(1, 10, 5, 6, 1, 0);
      chk("first_addr", {17'd0, mem.mem_addr}, 810);
      chk("first_data", {29'd0, mem.mem_data}, 6);
      cycle(0, 0, 0, 0, 1, 0);
      chk("first_box_x0", {24'd0, oBoxX0}, 10);
      chk("first_box_y1", {25'd0, oBoxY1}, 5);

      // Overflow with the frame buffer stalled.
      w0 = writes_seen;
      for (int i = 0; i < 6; i++) cycle(1, 20 + i, 3, 2 + (i % 5), 0, 0);
      chk("ovf_drop", {24'd0, oDropCount}, 2);
      drain();
      chk("ovf_writes", writes_seen - w0, 4);

      // Clipping and the largest address.
      cycle(0, 0, 0, 0, 1, 1);
      cycle(1, 160, 0, 1, 1, 0);
      cycle(1, 0, 120, 1, 1, 0);
      cycle(1, 159, 119, 4, 1, 0);
      chk("clip_two",   {24'd0, oClipCount},   2);
      chk("max_addr",   {17'd0, mem.mem_addr}, 19199);
      drain();

      // Full FIFO streaming with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++) cycle(1, i, 9, 7, 0, 0);
      w0 = writes_seen;
      for (int i = 0; i < 10; i++) cycle(1, 50 + i, 60, 1 + (i % 7), 1, 0);
      chk("stream_full", {31'd0, oFull}, 1);
      drain();
      chk("stream_writes", writes_seen - w0, 14);

      // Dirty box and clear with a simultaneous plot.
      cycle(0, 0, 0, 0, 1, 1);
      cycle(1, 20, 30, 3, 1, 0);
      cycle(1, 5, 50, 3, 1, 0);
      cycle(1, 40, 2, 3, 1, 0);
      chk("box_pre_x0", {24'd0, oBoxX0}, 5);
      chk("box_pre_x1", {24'd0, oBoxX1}, 40);
      chk("box_pre_y0", {25'd0, oBoxY0}, 2);
      chk("box_pre_y1", {25'd0, oBoxY1}, 50);
      cycle(1, 7, 7, 5, 1, 1);
      chk("box_seed_x1", {24'd0, oBoxX1}, 7);
      chk("box_seed_y0", {25'd0, oBoxY0}, 7);
      drain();

      // Alternating black and colour 3.
      cycle(0, 0, 0, 0, 1, 1);
      w0 = writes_seen;
      for (int i = 0; i < 16; i++) cycle(1, 30 + i, 40 + i, (i % 2) * 3, 1, 0);
      drain();
`ifdef COLOUR_KEY_EN
      chk("key_writes", writes_seen - w0, 8);
      chk("key_box_x0", {24'd0, oBoxX0}, 31);
`else
      chk("key_writes", writes_seen - w0, 16);
      chk("key_box_x0", {24'd0, oBoxX0}, 30);
`endif

      // Reset while writes are still queued.
      for (int i = 0; i < 3; i++) cycle(1, 70 + i, 11, 2, 0, 0);
      do_reset();
      cycle(0, 0, 0, 0, 1, 0);

      // Randomized traffic.
      for (int n = 0; n < 2000; n++) begin
         clr = ($urandom_range(0, 49) == 0);
         x   = $urandom_range(0, 175);
         y   = $urandom_range(0, 127);
         c   = $urandom_range(0, 7);
         if (clr) begin
            x = x % 160;
            y = y % 120;
         end
         cycle($urandom_range(0, 9) < 7, x, y, c, $urandom_range(0, 9) < 6, clr);
      end
      drain();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
